// File: rtl/can_pkg.sv
// Shared definitions for the CAN receiver: FSM state encoding, frame-type codes,
// field lengths and the CRC-15 single-bit update.
package can_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SOF,
    ST_ARB,
    ST_CTRL,
    ST_DATA,
    ST_CRC,
    ST_CRCDEL,
    ST_ACK,
    ST_EOF,
    ST_ERRWAIT
  } can_state_t;

  localparam logic [1:0] FT_DATA     = 2'd0;
  localparam logic [1:0] FT_REMOTE   = 2'd1;
  localparam logic [1:0] FT_ERROR    = 2'd2;
  localparam logic [1:0] FT_OVERLOAD = 2'd3;

  localparam logic [14:0] CRC15_POLY = 15'h4599;
  localparam int          EOF_LEN    = 7;
  localparam int          IDLE_LEN   = 11;

  // One MSB-first step of the CAN CRC-15 shift register.
  function automatic logic [14:0] crc15_step(input logic [14:0] crc, input logic b);
    logic [14:0] shifted;
    shifted = {crc[13:0], 1'b0};
    return (b ^ crc[14]) ? (shifted ^ CRC15_POLY) : shifted;
  endfunction

endpackage

// File: rtl/can_bit_timing.sv
// Bit-time generator: captures the timing configuration on hard sync and produces
// a one-clock sample strobe and a last-clock-of-bit strobe while a frame is active.
module can_bit_timing (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_sync,
  input  logic       i_run,
  input  logic [7:0] i_quanta_div,
  input  logic [2:0] i_prop,
  input  logic [2:0] i_seg1,
  input  logic [2:0] i_seg2,
  output logic       o_sample,
  output logic       o_bit_end
);

  logic [4:0]  w_q_sp;
  logic [4:0]  w_q_bit;
  logic [12:0] w_nbit;
  logic [12:0] w_sp;
  logic [12:0] r_cnt;
  logic [12:0] r_nbit;
  logic [12:0] r_sp;

  assign w_q_sp  = 5'd1 + {2'b00, i_prop} + {2'b00, i_seg1};
  assign w_q_bit = w_q_sp + {2'b00, i_seg2};
  assign w_nbit  = {8'd0, w_q_bit} * {5'd0, i_quanta_div};
  assign w_sp    = {8'd0, w_q_sp} * {5'd0, i_quanta_div};

  // Timing is frozen at hard sync so mid-frame input changes have no effect.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_nbit <= '0;
      r_sp   <= '0;
    end else if (i_sync) begin
      r_cnt  <= '0;
      r_nbit <= w_nbit;
      r_sp   <= w_sp;
    end else if (i_run) begin
      r_cnt <= o_bit_end ? 13'd0 : r_cnt + 13'd1;
    end
  end

  assign o_bit_end = i_run && (r_cnt == r_nbit - 13'd1);
  assign o_sample  = i_run && (r_cnt == r_sp);

endmodule

// File: rtl/can_rcv.sv
// CAN 2.0A/B frame receiver: FSM, bit destuffing, CRC-15 check and result registers.
// Optional ACK driving is enabled by defining CAN_RCV_ACK_EN.
module can_rcv
  import can_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        din,
  input  logic [7:0]  quantaDiv,
  input  logic [2:0]  propQuanta,
  input  logic [2:0]  seg1Quanta,
  input  logic [2:0]  seg2Quanta,
  output logic        busy,
  output logic        rxValid,
  output logic [28:0] rxId,
  output logic        rxFormat,
  output logic [1:0]  rxFrameType,
  output logic [3:0]  rxDatalen,
  output logic [63:0] rxData,
  output logic        crcErr,
  output logic        stuffErr,
  output logic        formErr,
  output logic        ackDrive
);

  can_state_t  r_state;
  can_state_t  w_state_nxt;
  logic [5:0]  r_bitcnt;
  logic [2:0]  r_run;
  logic        r_last;
  logic [14:0] r_crc;
  logic [14:0] r_crc_rx;
  logic [28:0] r_id;
  logic        r_rtr;
  logic        r_ide;
  logic [3:0]  r_dlc;
  logic [63:0] r_data;

  logic        w_sample;
  logic        w_bit_end;
  logic        w_sync;
  logic        w_in_stuff;
  logic        w_stuff_bit;
  logic        w_data_bit;
  logic [2:0]  w_run_nxt;
  logic [3:0]  w_dlc_shift;
  logic [3:0]  w_bytes;
  logic        w_valid;
  logic        w_stuff_err;
  logic        w_form_err;
  logic        w_crc_err;

  can_bit_timing u_timing (
    .clk          (clk),
    .rst          (rst),
    .i_sync       (w_sync),
    .i_run        (r_state != ST_IDLE),
    .i_quanta_div (quantaDiv),
    .i_prop       (propQuanta),
    .i_seg1       (seg1Quanta),
    .i_seg2       (seg2Quanta),
    .o_sample     (w_sample),
    .o_bit_end    (w_bit_end)
  );

  assign w_in_stuff  = r_state inside {ST_SOF, ST_ARB, ST_CTRL, ST_DATA, ST_CRC};
  assign w_stuff_bit = w_in_stuff && (r_run == 3'd5);
  assign w_data_bit  = w_sample && w_in_stuff && !w_stuff_bit;
  assign w_run_nxt   = (din == r_last) ? r_run + 3'd1 : 3'd1;
  assign w_dlc_shift = {r_dlc[2:0], din};
  assign w_bytes     = (r_dlc > 4'd8) ? 4'd8 : r_dlc;
  assign busy        = (r_state != ST_IDLE);

  always_comb begin
    w_state_nxt = r_state;
    w_sync      = 1'b0;
    w_valid     = 1'b0;
    w_stuff_err = 1'b0;
    w_form_err  = 1'b0;
    w_crc_err   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!din) begin
          w_sync      = 1'b1;
          w_state_nxt = ST_SOF;
        end
      end
      ST_SOF: begin
        if (w_sample) w_state_nxt = din ? ST_IDLE : ST_ARB;
      end
      ST_ARB: begin
        if (w_data_bit && ((r_bitcnt == 6'd12 && !din) || r_bitcnt == 6'd31))
          w_state_nxt = ST_CTRL;
      end
      ST_CTRL: begin
        if (w_data_bit && r_bitcnt == (r_ide ? 6'd5 : 6'd4))
          w_state_nxt = (r_rtr || w_dlc_shift == 4'd0) ? ST_CRC : ST_DATA;
      end
      ST_DATA: begin
        if (w_data_bit && ({1'b0, r_bitcnt} == {w_bytes, 3'b000} - 7'd1))
          w_state_nxt = ST_CRC;
      end
      ST_CRC: begin
        // A run of five ending on the last CRC bit is followed by one more stuff bit.
        if (w_data_bit && r_bitcnt == 6'd14 && w_run_nxt != 3'd5)
          w_state_nxt = ST_CRCDEL;
        else if (w_sample && w_stuff_bit && r_bitcnt == 6'd15)
          w_state_nxt = ST_CRCDEL;
      end
      ST_CRCDEL: begin
        if (w_sample) begin
          if (!din) begin
            w_form_err  = 1'b1;
            w_state_nxt = ST_ERRWAIT;
          end else if (r_crc_rx != r_crc) begin
            w_crc_err   = 1'b1;
            w_state_nxt = ST_ERRWAIT;
          end else begin
            w_valid     = 1'b1;
            w_state_nxt = ST_ACK;
          end
        end
      end
      ST_ACK: begin
        if (w_sample) w_state_nxt = ST_EOF;
      end
      ST_EOF: begin
        if (w_sample) begin
          if (!din) begin
            w_form_err  = 1'b1;
            w_state_nxt = ST_ERRWAIT;
          end else if (r_bitcnt == 6'(EOF_LEN - 1)) begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      ST_ERRWAIT: begin
        if (w_sample && din && r_bitcnt == 6'(IDLE_LEN - 1)) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_sample && w_stuff_bit && (din == r_last)) begin
      w_stuff_err = 1'b1;
      w_state_nxt = ST_ERRWAIT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_bitcnt    <= '0;
      r_run       <= '0;
      r_last      <= 1'b1;
      r_crc       <= '0;
      r_crc_rx    <= '0;
      r_id        <= '0;
      r_rtr       <= 1'b0;
      r_ide       <= 1'b0;
      r_dlc       <= '0;
      r_data      <= '0;
      rxValid     <= 1'b0;
      rxId        <= '0;
      rxFormat    <= 1'b0;
      rxFrameType <= '0;
      rxDatalen   <= '0;
      rxData      <= '0;
      crcErr      <= 1'b0;
      stuffErr    <= 1'b0;
      formErr     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      rxValid  <= w_valid;
      crcErr   <= w_crc_err;
      stuffErr <= w_stuff_err;
      formErr  <= w_form_err;

      if (w_state_nxt != r_state)
        r_bitcnt <= '0;
      else if (r_state == ST_ERRWAIT && w_sample)
        r_bitcnt <= din ? r_bitcnt + 6'd1 : 6'd0;
      else if (w_data_bit || (w_sample && !w_in_stuff))
        r_bitcnt <= r_bitcnt + 6'd1;

      if (w_sync) begin
        r_run    <= '0;
        r_last   <= 1'b1;
        r_crc    <= '0;
        r_crc_rx <= '0;
        r_id     <= '0;
        r_rtr    <= 1'b0;
        r_ide    <= 1'b0;
        r_dlc    <= '0;
        r_data   <= '0;
      end else begin
        // A valid stuff bit differs from r_last, so it restarts the run at 1.
        if (w_sample && w_in_stuff) begin
          r_run  <= w_run_nxt;
          r_last <= din;
        end
        if (w_data_bit && r_state != ST_CRC) r_crc <= crc15_step(r_crc, din);
        if (w_data_bit) begin
          case (r_state)
            ST_ARB: begin
              if (r_bitcnt == 6'd11 || r_bitcnt == 6'd31) r_rtr <= din;
              else if (r_bitcnt == 6'd12) r_ide <= din;
              else r_id <= {r_id[27:0], din};
            end
            ST_CTRL: r_dlc <= w_dlc_shift;
            ST_DATA: r_data[6'd63 - r_bitcnt] <= din;
            ST_CRC:  r_crc_rx <= {r_crc_rx[13:0], din};
            default: ;
          endcase
        end
      end

      if (w_valid) begin
        rxId        <= r_ide ? r_id : {r_id[10:0], 18'd0};
        rxFormat    <= r_ide;
        rxFrameType <= r_rtr ? FT_REMOTE : FT_DATA;
        rxDatalen   <= r_dlc;
        rxData      <= r_data;
      end
    end
  end

`ifdef CAN_RCV_ACK_EN
  // ACK is only reached after a good CRC; drive across the full following bit.
  logic r_ack;
  always_ff @(posedge clk) begin
    if (rst)
      r_ack <= 1'b0;
    else if (r_ack && w_bit_end)
      r_ack <= 1'b0;
    else if (r_state == ST_ACK && w_bit_end)
      r_ack <= 1'b1;
  end
  assign ackDrive = r_ack;
`else
  logic w_unused_bit_end;
  assign w_unused_bit_end = w_bit_end;
  assign ackDrive         = 1'b0;
`endif

endmodule
